// File: rtl/irq_ack_decoder_pkg.sv
// Shared widths for the interrupt subsystem.
// The pending/acknowledge block and the priority encoder both take their
// default sizes from here, so the two instances always agree on them.
package irq_ack_decoder_pkg;

  // Number of interrupt request lines.
  localparam int NrOfInputBits  = 4;
  // Width of the binary interrupt address the core acknowledges.
  localparam int NrOfSelectBits = 2;

endpackage : irq_ack_decoder_pkg

// File: rtl/irq_ack_decoder_onehot_decoder.sv
// Binary-to-one-hot decoder with a range flag.
// This is the inverse of the priority encoder. An address at or above
// NrOfInputBits gives an all-zero one-hot and in_range = 0.
module onehot_decoder
  import irq_ack_decoder_pkg::*;
#(
  parameter int NrOfInputBits  = irq_ack_decoder_pkg::NrOfInputBits,
  parameter int NrOfSelectBits = irq_ack_decoder_pkg::NrOfSelectBits
) (
  input  logic [NrOfSelectBits-1:0] addr,
  output logic [NrOfInputBits-1:0]  onehot,
  output logic                      in_range
);

  // Compare the address against every legal index. No index can match an
  // out-of-range address, so both outputs stay zero for it.
  always_comb begin
    onehot   = '0;
    in_range = 1'b0;
    for (int i = 0; i < NrOfInputBits; i++) begin
      if (addr == NrOfSelectBits'(i)) begin
        onehot[i] = 1'b1;
        in_range  = 1'b1;
      end
    end
  end

endmodule : onehot_decoder

// File: rtl/irq_ack_decoder.sv
// Interrupt pending/acknowledge block.
// Rising edges on irq_in set bits in the pending vector. A legal acknowledge
// from the core clears one pending bit. Every output comes straight from a
// flop and gives the acknowledge result one cycle after ack_valid.
module irq_ack_decoder
  import irq_ack_decoder_pkg::*;
#(
  parameter int NrOfInputBits  = irq_ack_decoder_pkg::NrOfInputBits,
  parameter int NrOfSelectBits = irq_ack_decoder_pkg::NrOfSelectBits
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NrOfInputBits-1:0]  irq_in,
  input  logic                      ack_valid,
  input  logic [NrOfSelectBits-1:0] ack_addr,
  output logic [NrOfInputBits-1:0]  pending,
  output logic [NrOfInputBits-1:0]  ack_onehot,
  output logic                      ack_done,
  output logic                      ack_err
);

  logic [NrOfInputBits-1:0] irq_prev_q, irq_prev_d;
  logic [NrOfInputBits-1:0] pending_q, pending_d;
  logic [NrOfInputBits-1:0] ack_onehot_q, ack_onehot_d;
  logic                     ack_done_q, ack_done_d;
  logic                     ack_err_q, ack_err_d;

  logic [NrOfInputBits-1:0] dec_onehot;
  logic                     dec_in_range;
  logic [NrOfInputBits-1:0] rise;
  logic [NrOfInputBits-1:0] clr;
  logic                     ack_legal;

  onehot_decoder #(
    .NrOfInputBits (NrOfInputBits),
    .NrOfSelectBits(NrOfSelectBits)
  ) u_onehot_decoder (
    .addr    (ack_addr),
    .onehot  (dec_onehot),
    .in_range(dec_in_range)
  );

  // Judge the acknowledge against pending as it stood before this edge.
  // A rise captured at the same edge cannot make the acknowledge legal.
  always_comb begin
    rise      = irq_in & ~irq_prev_q;
    ack_legal = ack_valid & dec_in_range & (|(dec_onehot & pending_q));
    clr       = ack_legal ? dec_onehot : '0;
  end

  // Apply the clear first and the set second, so a new event on the
  // acknowledged bit is kept.
  always_comb begin
    irq_prev_d = irq_in;
    pending_d  = (pending_q & ~clr) | rise;
  end

  // Result of this cycle's acknowledge. It is all zero when no ack is present.
  always_comb begin
    ack_done_d   = ack_legal;
    ack_err_d    = ack_valid & ~ack_legal;
    ack_onehot_d = clr;
  end

  // State and result registers. Reset clears them all, so an acknowledge
  // that arrives during reset is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev_q   <= '0;
      pending_q    <= '0;
      ack_onehot_q <= '0;
      ack_done_q   <= 1'b0;
      ack_err_q    <= 1'b0;
    end else begin
      irq_prev_q   <= irq_prev_d;
      pending_q    <= pending_d;
      ack_onehot_q <= ack_onehot_d;
      ack_done_q   <= ack_done_d;
      ack_err_q    <= ack_err_d;
    end
  end

  assign pending    = pending_q;
  assign ack_onehot = ack_onehot_q;
  assign ack_done   = ack_done_q;
  assign ack_err    = ack_err_q;

endmodule : irq_ack_decoder

// File: tb/tb_irq_ack_decoder.sv
// Testbench for irq_ack_decoder.
// It drives a default instance (N=4, S=2) and a narrow one (N=3, S=2).
// Both are compared against a bitmask reference model of pending events.
module tb_irq_ack_decoder;

  logic       clk;
  logic       rst_n;

  logic [3:0] irqIn;
  logic       ackValid;
  logic [1:0] ackAddr;
  logic [3:0] pending;
  logic [3:0] ackOnehot;
  logic       ackDone;
  logic       ackErr;

  logic [2:0] irqIn3;
  logic       ackValid3;
  logic [1:0] ackAddr3;
  logic [2:0] pending3;
  logic [2:0] ackOnehot3;
  logic       ackDone3;
  logic       ackErr3;

  int checks = 0;
  int errors = 0;

  // Reference state: a set of pending event numbers kept as a mask.
  longint modelPend, modelPrev, expOh;
  bit     expDone, expErr;
  longint modelPend3, modelPrev3, expOh3;
  bit     expDone3, expErr3;

  irq_ack_decoder #(.NrOfInputBits(4), .NrOfSelectBits(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irqIn),
    .ack_valid (ackValid),
    .ack_addr  (ackAddr),
    .pending   (pending),
    .ack_onehot(ackOnehot),
    .ack_done  (ackDone),
    .ack_err   (ackErr)
  );

  irq_ack_decoder #(.NrOfInputBits(3), .NrOfSelectBits(2)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irqIn3),
    .ack_valid (ackValid3),
    .ack_addr  (ackAddr3),
    .pending   (pending3),
    .ack_onehot(ackOnehot3),
    .ack_done  (ackDone3),
    .ack_err   (ackErr3)
  );

  // Free-running clock with rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance the reference by one clock edge for an instance with n lines.
  task automatic modelStep(input int n, input longint irq, input bit av, input int addr,
                           inout longint pend, inout longint prev,
                           output longint oh, output bit done, output bit err);
    longint mask;
    longint rise;
    bit     legal;
    mask  = (64'd1 << n) - 1;
    legal = av && (addr < n) && (((pend >> addr) & 1) == 1);
    rise  = irq & ~prev & mask;
    if (legal) pend = pend - (64'd1 << addr);
    pend  = pend | rise;
    prev  = irq & mask;
    oh    = legal ? (64'd1 << addr) : 0;
    done  = legal;
    err   = av && !legal;
  endtask

  task automatic modelReset();
    modelPend  = 0; modelPrev  = 0; expOh  = 0; expDone  = 0; expErr  = 0;
    modelPend3 = 0; modelPrev3 = 0; expOh3 = 0; expDone3 = 0; expErr3 = 0;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".pending"},    32'(pending),    32'(modelPend));
    checkVal({tag, ".ackOnehot"},  32'(ackOnehot),  32'(expOh));
    checkVal({tag, ".ackDone"},    32'(ackDone),    32'(expDone));
    checkVal({tag, ".ackErr"},     32'(ackErr),     32'(expErr));
    checkVal({tag, ".pending3"},   32'(pending3),   32'(modelPend3));
    checkVal({tag, ".ackOnehot3"}, 32'(ackOnehot3), 32'(expOh3));
    checkVal({tag, ".ackDone3"},   32'(ackDone3),   32'(expDone3));
    checkVal({tag, ".ackErr3"},    32'(ackErr3),    32'(expErr3));
  endtask

  task automatic applyStimulus(input logic [3:0] irq, input logic av, input logic [1:0] addr);
    irqIn = irq; ackValid = av; ackAddr = addr;
  endtask

  task automatic applyStimulus3(input logic [2:0] irq, input logic av, input logic [1:0] addr);
    irqIn3 = irq; ackValid3 = av; ackAddr3 = addr;
  endtask

  // One clock edge: step both references, then sample 1 ns later.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (rst_n) begin
      modelStep(4, longint'(irqIn), ackValid, int'(ackAddr), modelPend, modelPrev,
                expOh, expDone, expErr);
      modelStep(3, longint'(irqIn3), ackValid3, int'(ackAddr3), modelPend3, modelPrev3,
                expOh3, expDone3, expErr3);
    end
    #1;
    checkOutput(tag);
  endtask

  // Pulse reset between clock edges and check that the outputs clear at once.
  task automatic midCycleReset(input string tag);
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput(tag);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(4'b0101, 1'b0, 2'd0);
    applyStimulus3(3'b000, 1'b0, 2'd0);
    modelReset();
    #2;
    checkOutput("reset");
    #10 rst_n = 1'b1;

    // Lines already high at release count as rising edges.
    cycle("release");
    checkVal("release.pendingLit", 32'(pending), 32'h5);

    // Out-of-range acknowledge on the 3-line instance.
    applyStimulus(4'b0101, 1'b0, 2'd0);
    applyStimulus3(3'b000, 1'b1, 2'd3);
    cycle("n3.oorEmpty");
    applyStimulus3(3'b111, 1'b0, 2'd0);
    cycle("n3.fill");
    applyStimulus3(3'b111, 1'b1, 2'd3);
    cycle("n3.oorFull");
    checkVal("n3.errLit", 32'(ackErr3), 32'h1);
    checkVal("n3.pendLit", 32'(pending3), 32'h7);
    applyStimulus3(3'b111, 1'b0, 2'd0);

    // Clear the bits set at release.
    applyStimulus(4'b0101, 1'b1, 2'd0);
    cycle("clr0");
    applyStimulus(4'b0101, 1'b1, 2'd2);
    cycle("clr2");
    applyStimulus(4'b0000, 1'b0, 2'd0);
    cycle("idle");

    // Line 2 held high: one event, a stale ack on 1, then a legal ack on 2.
    applyStimulus(4'b0100, 1'b0, 2'd0);
    cycle("rise2");
    checkVal("rise2.pendingLit", 32'(pending), 32'h4);
    applyStimulus(4'b0100, 1'b1, 2'd1);
    cycle("stale1");
    checkVal("stale1.errLit", 32'(ackErr), 32'h1);
    checkVal("stale1.pendingLit", 32'(pending), 32'h4);
    applyStimulus(4'b0100, 1'b1, 2'd2);
    cycle("ack2");
    checkVal("ack2.onehotLit", 32'(ackOnehot), 32'h4);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(4'b0100, 1'b0, 2'd0);
      cycle("hold2");
    end
    checkVal("hold2.pendingLit", 32'(pending), 32'h0);

    // An ack and a re-rise on the same bit leave the bit pending.
    applyStimulus(4'b1000, 1'b0, 2'd0);
    cycle("rise3");
    applyStimulus(4'b0000, 1'b0, 2'd0);
    cycle("fall3");
    applyStimulus(4'b1000, 1'b1, 2'd3);
    cycle("ackRise3");
    checkVal("ackRise3.doneLit", 32'(ackDone), 32'h1);
    checkVal("ackRise3.pendingLit", 32'(pending), 32'h8);
    applyStimulus(4'b1000, 1'b1, 2'd3);
    cycle("ack3again");
    checkVal("ack3again.pendingLit", 32'(pending), 32'h0);

    // Back-to-back acknowledges, then a reset while the results are valid.
    applyStimulus(4'b0000, 1'b0, 2'd0);
    cycle("idle2");
    applyStimulus(4'b0011, 1'b0, 2'd0);
    cycle("rise01");
    applyStimulus(4'b0011, 1'b1, 2'd0);
    cycle("b2b0");
    checkVal("b2b0.onehotLit", 32'(ackOnehot), 32'h1);
    applyStimulus(4'b0011, 1'b1, 2'd1);
    cycle("b2b1");
    checkVal("b2b1.onehotLit", 32'(ackOnehot), 32'h2);
    checkVal("b2b1.pendingLit", 32'(pending), 32'h0);
    applyStimulus(4'b0011, 1'b1, 2'd0);
    midCycleReset("midRst");
    checkVal("midRst.doneLit", 32'(ackDone), 32'h0);
    cycle("afterRst");

    // Randomised traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) irqIn = 4'($urandom);
      if ($urandom_range(0, 3) == 0) irqIn3 = 3'($urandom);
      applyStimulus(irqIn, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      applyStimulus3(irqIn3, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      cycle("rand");
      if ($urandom_range(0, 49) == 0) midCycleReset("randRst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_irq_ack_decoder
